bus_mem_ctrl: RTL and testbench
===============================

BUS_MEM_CTRL -- requirements
Module: bus_mem_ctrl

Interface
- REQ-001 SHALL have parameter WAIT_STATES, default 2, range 0..15: number of wait cycles between request acceptance and completion.
- REQ-002 SHALL have parameter DEPTH, default 256: number of 8-bit memory words, addressed 0..DEPTH-1.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port req_rd, input, 1: read request, sampled only in IDLE.
- REQ-006 SHALL have port req_wr, input, 1: write request, sampled only in IDLE.
- REQ-007 SHALL have port addr, input, 8: request address.
- REQ-008 SHALL have port wdata, input, 8: write data.
- REQ-009 SHALL have port rdata, output, 8: read data, registered.
- REQ-010 SHALL have port bus_ready, output, 1: one-cycle completion pulse, consumed by the CPU controller FSM.
- REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.
- REQ-012 SHALL have port io_in, input, 8: external input port; used only with BUS_IO_PORT_EN.
- REQ-013 SHALL have port io_out, output, 8: external output port register; used only with BUS_IO_PORT_EN.

Function
- REQ-014 SHALL implement a three-state FSM: IDLE, WAIT and DONE.
- REQ-015 In IDLE, when req_rd or req_wr is high at a clock edge, the block SHALL do all of the following:
  - latch addr, wdata and the operation type;
  - load the wait counter with WAIT_STATES;
  - go to WAIT, or directly to DONE when WAIT_STATES=0.
- REQ-016 When req_rd and req_wr are both high in IDLE, the block SHALL perform the write and ignore the read.
- REQ-017 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to DONE on the edge where the counter equals 1.
- REQ-018 DONE SHALL last exactly one cycle, with bus_ready=1, and then return to IDLE.
- REQ-019 bus_ready SHALL be 0 in all other states.
- REQ-020 Latency: bus_ready SHALL be high in the cycle WAIT_STATES+1 cycles after the acceptance cycle (default: 3).
- REQ-021 A read SHALL update rdata on the edge entering DONE, so rdata is valid while bus_ready=1.
- REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
- REQ-023 A write SHALL commit wdata to memory on the edge entering DONE.
- REQ-024 Requests arriving while busy=1 SHALL be ignored and not queued; the requester re-asserts after bus_ready.
- REQ-025 A request held high through DONE SHALL be accepted again only in the following IDLE cycle; there SHALL be no back-to-back acceptance inside DONE.
- REQ-026 Address wrap: when addr >= DEPTH, the access SHALL target addr modulo DEPTH.
- REQ-027 Inputs other than those latched at acceptance SHALL NOT affect an in-flight access.

Reset
- REQ-028 When reset is high at an edge, the block SHALL set state=IDLE, bus_ready=0, busy=0, rdata=8'h00, io_out=8'h00 and wait counter=0.
- REQ-029 Reset mid-operation SHALL abort the access without emitting bus_ready, and an aborted write SHALL NOT modify memory.
- REQ-030 Memory contents SHALL NOT be cleared by reset; power-up content is all zeros.

Configuration
- REQ-031 Macro BUS_IO_PORT_EN SHALL control a memory-mapped I/O port at address 8'hFF.
  - Defined: a write to 8'hFF SHALL update io_out instead of memory; a read of 8'hFF SHALL return io_in as sampled on the edge entering DONE. Timing is unchanged.
  - Undefined: 8'hFF SHALL be ordinary memory; io_out SHALL be constant 8'h00 and io_in SHALL be unused.

Verification
- REQ-032 Write then read: write addr=8'h10 wdata=8'hA5, then read 8'h10 (WAIT_STATES=2) -> each bus_ready exactly 3 cycles after acceptance; read returns rdata=8'hA5.
- REQ-033 WAIT_STATES=0 build: read 8'h10 -> bus_ready in the cycle immediately after acceptance; busy high for exactly 1 cycle.
- REQ-034 Busy rejection: during an in-flight read of 8'h20 (memory holds 8'h5A), assert a write to 8'h20 with wdata=8'hFF -> write dropped; a later read of 8'h20 returns 8'h5A.
- REQ-035 Simultaneous request: req_rd=req_wr=1, addr=8'h30, wdata=8'h3C -> memory[8'h30]=8'h3C and rdata unchanged from its prior value.
- REQ-036 Reset abort: assert a write to 8'h40 (wdata=8'h77), then pulse reset one cycle later -> no bus_ready; state=IDLE; a subsequent read of 8'h40 returns its prior value 8'h00.
- REQ-037 With BUS_IO_PORT_EN: write 8'hFF with 8'hC3 -> io_out=8'hC3. With io_in=8'h96, read 8'hFF -> rdata=8'h96.

Source files
------------

// File: rtl/bus_mem_ctrl_if.sv
// bus_mem_ctrl_if: request/response bus between the CPU controller and bus_mem_ctrl,
// including the optional memory-mapped I/O port pins.
interface bus_mem_ctrl_if;
    logic       req_rd;
    logic       req_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       bus_ready;
    logic       busy;
    logic [7:0] io_in;
    logic [7:0] io_out;
    modport master (output req_rd, req_wr, addr, wdata, io_in, input rdata, bus_ready, busy, io_out);
    modport slave (input req_rd, req_wr, addr, wdata, io_in, output rdata, bus_ready, busy, io_out);
endinterface

// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: 8-bit memory behind an IDLE/WAIT/DONE handshake with WAIT_STATES latency.
// Define BUS_IO_PORT_EN to map io_in/io_out at address 8'hFF.
module bus_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH       = 256
) (
    input logic           clk,
    input logic           reset,
    bus_mem_ctrl_if.slave bus
);
    localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    addr_q, wdata_q, rdata_q;
    logic          wr_q;
    logic [7:0]    mem [DEPTH];
    logic          accept, commit, op_wr, io_hit;
    logic [7:0]    op_addr, op_wdata;
    logic [AW-1:0] idx;

    assign accept = state == IDLE && (bus.req_rd || bus.req_wr);
    assign commit = state_n == DONE;
    // With zero wait states the access completes on its acceptance edge, before anything is latched.
    assign op_wr    = state == IDLE ? bus.req_wr : wr_q;
    assign op_addr  = state == IDLE ? bus.addr : addr_q;
    assign op_wdata = state == IDLE ? bus.wdata : wdata_q;
    assign idx      = AW'(32'(op_addr) % DEPTH);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n   = accept ? 4'(WAIT_STATES) : cnt;
                state_n = !accept ? IDLE : WAIT_STATES == 0 ? DONE : WAIT;
            end
            WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? DONE : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                wr_q    <= bus.req_wr;
            end
            if (commit && !op_wr)
                rdata_q <= io_hit ? bus.io_in : mem[idx];
        end
    end

    // Memory is deliberately outside the reset branch so its contents survive reset.
    always_ff @(posedge clk)
        if (!reset && commit && op_wr && !io_hit)
            mem[idx] <= op_wdata;

`ifdef BUS_IO_PORT_EN
    logic [7:0] io_q;
    assign io_hit = op_addr == 8'hFF;
    always_ff @(posedge clk)
        if (reset)
            io_q <= 8'h00;
        else if (commit && op_wr && io_hit)
            io_q <= op_wdata;
    assign bus.io_out = io_q;
`else
    assign io_hit     = 1'b0;
    assign bus.io_out = 8'h00;
`endif

    assign bus.rdata     = rdata_q;
    assign bus.bus_ready = state == DONE;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: table vectors, directed corner sequences and random traffic against a
// behavioural memory model, on a WAIT_STATES=2/DEPTH=256 and a WAIT_STATES=0/DEPTH=128 instance.
module tb_bus_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_mem_ctrl_if b ();
    bus_mem_ctrl_if b0 ();
    bus_mem_ctrl #(.WAIT_STATES(2), .DEPTH(256)) dut (.clk(clk), .reset(reset), .bus(b));
    bus_mem_ctrl #(.WAIT_STATES(0), .DEPTH(128)) dut0 (.clk(clk), .reset(reset), .bus(b0));

`ifdef BUS_IO_PORT_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mem_m [2][256];
    logic [7:0] rd_m [2];
    logic [7:0] io_m [2];

    function automatic int ws(bit s);
        return s ? 0 : 2;
    endfunction
    function automatic int dep(bit s);
        return s ? 128 : 256;
    endfunction
    function automatic logic rdy(bit s);
        return s ? b0.bus_ready : b.bus_ready;
    endfunction
    function automatic logic bsy(bit s);
        return s ? b0.busy : b.busy;
    endfunction
    function automatic logic [7:0] rdat(bit s);
        return s ? b0.rdata : b.rdata;
    endfunction
    function automatic logic [7:0] iout(bit s);
        return s ? b0.io_out : b.io_out;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: write wins over read, address folds modulo depth, 8'hFF is I/O when enabled.
    task automatic model(input bit s, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] io);
        int k;
        k = int'(a) % dep(s);
        if (wr) begin
            if (IO_EN && a == 8'hFF) io_m[s] = d;
            else mem_m[s][k] = d;
        end else if (rd) begin
            rd_m[s] = (IO_EN && a == 8'hFF) ? io : mem_m[s][k];
        end
    endtask

    task automatic drive(input bit s, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        if (s) begin
            b0.req_rd = rd; b0.req_wr = wr; b0.addr = a; b0.wdata = d;
        end else begin
            b.req_rd = rd; b.req_wr = wr; b.addr = a; b.wdata = d;
        end
    endtask

    task automatic op(input bit s, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input string name);
        int lat;
        logic [7:0] io;
        lat = 0;
        io = s ? b0.io_in : b.io_in;
        @(negedge clk);
        drive(s, rd, wr, a, d);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        model(s, rd, wr, a, d, io);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (rdy(s)) lat = i;
        end
        chk({name, " latency"}, lat, ws(s) + 1);
        chk({name, " rdata"}, rdat(s), rd_m[s]);
        chk({name, " io_out"}, iout(s), io_m[s]);
    endtask

    initial begin
        vec_t       tbl [8];
        bit         s, seen;
        int         m;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            mem_m[0][i] = 8'h00;
            mem_m[1][i] = 8'h00;
        end
        rd_m = '{8'h00, 8'h00};
        io_m = '{8'h00, 8'h00};
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        b.io_in = 8'h00;
        b0.io_in = 8'h00;
        tbl[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{1'b0, 1'b1, 8'h20, 8'h5A, 8'hA5};
        tbl[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
        tbl[4] = '{1'b1, 1'b1, 8'h30, 8'h3C, 8'h5A};
        tbl[5] = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h3C};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[7] = '{1'b0, 1'b1, 8'h10, 8'h66, 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", bsy(1'(i)), 0);
            chk("reset bus_ready", rdy(1'(i)), 0);
            chk("reset rdata", rdat(1'(i)), 8'h00);
            chk("reset io_out", iout(1'(i)), 8'h00);
        end

        for (int i = 0; i < 8; i++) begin
            op(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, "table");
            chk("table expected rdata", b.rdata, tbl[i].exp);
        end

        // A write issued while a read of 8'h20 is in flight must be dropped.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 8'h20, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("busy-reject bus_ready", b.bus_ready, 1);
        chk("busy-reject rdata", b.rdata, 8'h5A);
        @(negedge clk);
        chk("busy-reject dropped", b.busy, 0);
        op(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "busy-reject reread");
        chk("busy-reject value", b.rdata, 8'h5A);

        // A read held high is re-accepted only after one IDLE cycle following DONE.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("held busy pattern", b.busy, (i % (ws(0) + 2)) != ws(0) + 1);
            chk("held bus_ready pattern", b.bus_ready, (i % (ws(0) + 2)) == ws(0));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        model(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        @(negedge clk);
        chk("held rdata", b.rdata, rd_m[0]);
        @(negedge clk);
        chk("held released", b.busy, 0);

        // Zero-wait instance: single busy cycle, completion right after acceptance.
        op(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, "ws0 write");
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        model(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        @(negedge clk);
        chk("ws0 bus_ready", b0.bus_ready, 1);
        chk("ws0 busy", b0.busy, 1);
        chk("ws0 rdata", b0.rdata, 8'hA5);
        @(negedge clk);
        chk("ws0 busy end", b0.busy, 0);
        chk("ws0 bus_ready end", b0.bus_ready, 0);

        op(1'b1, 1'b0, 1'b1, 8'h85, 8'h11, "wrap write");
        op(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, "wrap read");
        chk("wrap value", b0.rdata, 8'h11);

        op(1'b0, 1'b0, 1'b1, 8'hFF, 8'hC3, "io write");
        chk("io_out value", b.io_out, IO_EN ? 8'hC3 : 8'h00);
        b.io_in = 8'h96;
        op(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, "io read");
        chk("io read value", b.rdata, IO_EN ? 8'h96 : 8'hC3);

        // Reset one cycle into a write: no completion, no memory update.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 8'h40, 8'h77);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        seen = b.bus_ready;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            seen |= b.bus_ready;
            @(negedge clk);
        end
        rd_m = '{8'h00, 8'h00};
        io_m = '{8'h00, 8'h00};
        chk("abort no bus_ready", seen, 0);
        chk("abort idle", b.busy, 0);
        chk("abort rdata reset", b.rdata, 8'h00);
        op(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, "abort reread");
        chk("abort memory kept", b.rdata, 8'h00);

        for (int n = 0; n < 150; n++) begin
            s = 1'($urandom);
            m = $urandom_range(0, 2);
            a = ($urandom_range(0, 4) == 0) ? 8'hFF : ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 7));
            if (s) b0.io_in = 8'($urandom);
            else b.io_in = 8'($urandom);
            op(s, m != 1, m != 0, a, 8'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
